// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter/sequencer sharing one memory port between icache and dcache
module mem_arbiter #(
  parameter int MEM_ADDR_BITS = 28,
  parameter int MEM_TAG_BITS  = 5,
  parameter int MEM_DATA_BITS = 128,
  parameter int DATA_CYCLES   = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ic_req_valid,
  output logic                       ic_req_ready,
  input  logic [MEM_ADDR_BITS-1:0]   ic_req_addr,
  input  logic [MEM_TAG_BITS-1:0]    ic_req_tag,
  output logic                       ic_resp_valid,
  output logic [MEM_DATA_BITS-1:0]   ic_resp_data,
  output logic [MEM_TAG_BITS-1:0]    ic_resp_tag,
  input  logic                       dc_req_valid,
  output logic                       dc_req_ready,
  input  logic                       dc_req_rw,
  input  logic [MEM_ADDR_BITS-1:0]   dc_req_addr,
  input  logic [MEM_TAG_BITS-1:0]    dc_req_tag,
  input  logic                       dc_req_data_valid,
  output logic                       dc_req_data_ready,
  input  logic [MEM_DATA_BITS-1:0]   dc_req_data_bits,
  input  logic [MEM_DATA_BITS/8-1:0] dc_req_data_mask,
  output logic                       dc_resp_valid,
  output logic [MEM_DATA_BITS-1:0]   dc_resp_data,
  output logic [MEM_TAG_BITS-1:0]    dc_resp_tag,
  output logic                       mem_req_valid,
  input  logic                       mem_req_ready,
  output logic                       mem_req_rw,
  output logic [MEM_ADDR_BITS-1:0]   mem_req_addr,
  output logic [MEM_TAG_BITS-1:0]    mem_req_tag,
  output logic                       mem_req_data_valid,
  input  logic                       mem_req_data_ready,
  output logic [MEM_DATA_BITS-1:0]   mem_req_data_bits,
  output logic [MEM_DATA_BITS/8-1:0] mem_req_data_mask,
  input  logic                       mem_resp_valid,
  input  logic [MEM_DATA_BITS-1:0]   mem_resp_data,
  input  logic [MEM_TAG_BITS-1:0]    mem_resp_tag
);
  localparam int CW = DATA_CYCLES > 1 ? $clog2(DATA_CYCLES) : 1;
  typedef enum logic [1:0] {IDLE, RD_BURST, WR_DATA} state_t;
  state_t state, state_n;
  logic owner, last, lock, lock_sel;
  logic [CW-1:0] cnt;
  logic sel, idle, addr_hs, wr_hs, rd_beat;
  // a stalled selection is pinned so a late-arriving tie cannot steal the port
  assign sel = lock ? lock_sel : ((ic_req_valid && dc_req_valid) ? ~last : dc_req_valid);
  assign idle = reset && state == IDLE;
  assign mem_req_valid = idle && (sel ? dc_req_valid : ic_req_valid);
  assign mem_req_rw = sel & dc_req_rw;
  assign mem_req_addr = sel ? dc_req_addr : ic_req_addr;
  assign mem_req_tag = sel ? dc_req_tag : ic_req_tag;
  assign ic_req_ready = idle && !sel && mem_req_ready;
  assign dc_req_ready = idle && sel && mem_req_ready;
  assign addr_hs = mem_req_valid && mem_req_ready;
  assign mem_req_data_valid = reset && state == WR_DATA && dc_req_data_valid;
  assign dc_req_data_ready = reset && state == WR_DATA && mem_req_data_ready;
  assign mem_req_data_bits = dc_req_data_bits;
  assign mem_req_data_mask = dc_req_data_mask;
  assign wr_hs = mem_req_data_valid && mem_req_data_ready;
  assign rd_beat = reset && state == RD_BURST && mem_resp_valid;
  assign ic_resp_valid = rd_beat && !owner;
  assign dc_resp_valid = rd_beat && owner;
  assign ic_resp_data = mem_resp_data;
  assign dc_resp_data = mem_resp_data;
  assign ic_resp_tag = mem_resp_tag;
  assign dc_resp_tag = mem_resp_tag;
  always_comb begin
    state_n = (state == RD_BURST || state == WR_DATA) ? state : IDLE;
    if (state == IDLE && addr_hs) state_n = mem_req_rw ? WR_DATA : RD_BURST;
    if (rd_beat && cnt == CW'(DATA_CYCLES - 1)) state_n = IDLE;
    if (wr_hs) state_n = IDLE;
  end
  always_ff @(posedge clk)
    if (!reset) begin
      state <= IDLE;
      owner <= 1'b0;
      last <= 1'b0;
      cnt <= '0;
      lock <= 1'b0;
      lock_sel <= 1'b0;
    end else begin
      state <= state_n;
      lock <= idle && mem_req_valid && !mem_req_ready;
      lock_sel <= sel;
      if (addr_hs) begin
        owner <= sel;
        last <= sel;
        cnt <= '0;
      end else if (rd_beat) cnt <= cnt + CW'(1);
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenario tests for mem_arbiter with hand-computed expectations
module tb_mem_arbiter;
  localparam int AW = 28, TW = 5, DW = 128, MW = 16;
  logic clk, reset;
  logic ic_req_valid, ic_req_ready, ic_resp_valid;
  logic [AW-1:0] ic_req_addr, dc_req_addr, mem_req_addr;
  logic [TW-1:0] ic_req_tag, dc_req_tag, mem_req_tag, ic_resp_tag, dc_resp_tag, mem_resp_tag;
  logic [DW-1:0] ic_resp_data, dc_resp_data, dc_req_data_bits, mem_req_data_bits, mem_resp_data;
  logic [MW-1:0] dc_req_data_mask, mem_req_data_mask;
  logic dc_req_valid, dc_req_ready, dc_req_rw, dc_req_data_valid, dc_req_data_ready, dc_resp_valid;
  logic mem_req_valid, mem_req_ready, mem_req_rw, mem_req_data_valid, mem_req_data_ready, mem_resp_valid;
  logic [DW-1:0] mem_word;
  int checks = 0, errors = 0;

  mem_arbiter #(.MEM_ADDR_BITS(AW), .MEM_TAG_BITS(TW), .MEM_DATA_BITS(DW), .DATA_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .ic_req_valid(ic_req_valid), .ic_req_ready(ic_req_ready), .ic_req_addr(ic_req_addr), .ic_req_tag(ic_req_tag),
    .ic_resp_valid(ic_resp_valid), .ic_resp_data(ic_resp_data), .ic_resp_tag(ic_resp_tag),
    .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready), .dc_req_rw(dc_req_rw),
    .dc_req_addr(dc_req_addr), .dc_req_tag(dc_req_tag),
    .dc_req_data_valid(dc_req_data_valid), .dc_req_data_ready(dc_req_data_ready),
    .dc_req_data_bits(dc_req_data_bits), .dc_req_data_mask(dc_req_data_mask),
    .dc_resp_valid(dc_resp_valid), .dc_resp_data(dc_resp_data), .dc_resp_tag(dc_resp_tag),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_rw(mem_req_rw),
    .mem_req_addr(mem_req_addr), .mem_req_tag(mem_req_tag),
    .mem_req_data_valid(mem_req_data_valid), .mem_req_data_ready(mem_req_data_ready),
    .mem_req_data_bits(mem_req_data_bits), .mem_req_data_mask(mem_req_data_mask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data), .mem_resp_tag(mem_resp_tag)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic clear_inputs;
    ic_req_valid = 0; ic_req_addr = '0; ic_req_tag = '0;
    dc_req_valid = 0; dc_req_rw = 0; dc_req_addr = '0; dc_req_tag = '0;
    dc_req_data_valid = 0; dc_req_data_bits = '0; dc_req_data_mask = '0;
    mem_req_ready = 0; mem_req_data_ready = 0; mem_resp_valid = 0; mem_resp_data = '0; mem_resp_tag = '0;
  endtask

  task automatic do_reset;
    reset = 0;
    tick; tick;
    reset = 1;
  endtask

  // drives a full 4-beat read response and checks routing to the expected owner
  task automatic burst(input logic to_dc, input logic [TW-1:0] t, input logic [DW-1:0] d0);
    for (int i = 0; i < 4; i++) begin
      mem_resp_valid = 1; mem_resp_data = d0 + DW'(i); mem_resp_tag = t; #1;
      checks++; if ({ic_resp_valid, dc_resp_valid} !== (to_dc ? 2'b01 : 2'b10)) begin errors++; $display("FAIL burst_valid beat %0d got %b exp %b", i, {ic_resp_valid, dc_resp_valid}, to_dc ? 2'b01 : 2'b10); end
      checks++; if ((to_dc ? dc_resp_data : ic_resp_data) !== d0 + DW'(i)) begin errors++; $display("FAIL burst_data beat %0d got %0h exp %0h", i, to_dc ? dc_resp_data : ic_resp_data, d0 + DW'(i)); end
      checks++; if ((to_dc ? dc_resp_tag : ic_resp_tag) !== t) begin errors++; $display("FAIL burst_tag beat %0d got %0h exp %0h", i, to_dc ? dc_resp_tag : ic_resp_tag, t); end
      tick;
    end
    mem_resp_valid = 0;
  endtask

  task automatic test_reset;
    clear_inputs;
    reset = 0;
    ic_req_valid = 1; dc_req_valid = 1; mem_req_ready = 1; mem_resp_valid = 1;
    mem_req_data_ready = 1; dc_req_data_valid = 1; #1;
    checks++; if ({mem_req_valid, ic_req_ready, dc_req_ready, ic_resp_valid, dc_resp_valid, mem_req_data_valid, dc_req_data_ready} !== 7'b0) begin errors++; $display("FAIL reset_outputs got %b exp 0", {mem_req_valid, ic_req_ready, dc_req_ready, ic_resp_valid, dc_resp_valid, mem_req_data_valid, dc_req_data_ready}); end
    tick; tick;
    clear_inputs;
    reset = 1;
    tick;
  endtask

  task automatic test_ic_read;
    ic_req_valid = 1; ic_req_addr = 28'h100; ic_req_tag = 5'd3; mem_req_ready = 1; #1;
    checks++; if ({mem_req_valid, mem_req_rw, ic_req_ready, dc_req_ready} !== 4'b1010) begin errors++; $display("FAIL ic_req_ctrl got %b exp 1010", {mem_req_valid, mem_req_rw, ic_req_ready, dc_req_ready}); end
    checks++; if ({mem_req_addr, mem_req_tag} !== {28'h100, 5'd3}) begin errors++; $display("FAIL ic_req_fields got %0h/%0h exp 100/3", mem_req_addr, mem_req_tag); end
    tick;
    ic_req_valid = 0; #1;
    checks++; if ({mem_req_valid, ic_req_ready} !== 2'b00) begin errors++; $display("FAIL ic_busy_block got %b exp 00", {mem_req_valid, ic_req_ready}); end
    burst(0, 5'd3, 128'hD0);
    ic_req_valid = 1; mem_req_ready = 0; #1;
    checks++; if (mem_req_valid !== 1'b1) begin errors++; $display("FAIL ic_back_idle got %b exp 1", mem_req_valid); end
    ic_req_valid = 0;
    tick;
  endtask

  task automatic test_round_robin;
    do_reset;
    ic_req_valid = 1; ic_req_addr = 28'h40; ic_req_tag = 5'd1;
    dc_req_valid = 1; dc_req_rw = 0; dc_req_addr = 28'h80; dc_req_tag = 5'd2; mem_req_ready = 1; #1;
    checks++; if ({mem_req_addr, dc_req_ready, ic_req_ready} !== {28'h80, 2'b10}) begin errors++; $display("FAIL rr_first_dc got %0h/%b exp 80/10", mem_req_addr, {dc_req_ready, ic_req_ready}); end
    tick;
    dc_req_valid = 0; #1;
    checks++; if ({mem_req_valid, ic_req_ready} !== 2'b00) begin errors++; $display("FAIL rr_ic_waits got %b exp 00", {mem_req_valid, ic_req_ready}); end
    burst(1, 5'd2, 128'h100);
    #1;
    checks++; if ({mem_req_addr, ic_req_ready} !== {28'h40, 1'b1}) begin errors++; $display("FAIL rr_ic_next got %0h/%b exp 40/1", mem_req_addr, ic_req_ready); end
    tick;
    burst(0, 5'd1, 128'h200);
    dc_req_valid = 1; #1;
    checks++; if ({mem_req_addr, dc_req_ready} !== {28'h80, 1'b1}) begin errors++; $display("FAIL rr_third_dc got %0h/%b exp 80/1", mem_req_addr, dc_req_ready); end
    tick;
    dc_req_valid = 0;
    burst(1, 5'd2, 128'h300);
    dc_req_valid = 1; #1;
    checks++; if ({mem_req_addr, ic_req_ready} !== {28'h40, 1'b1}) begin errors++; $display("FAIL rr_fourth_ic got %0h/%b exp 40/1", mem_req_addr, ic_req_ready); end
    tick;
    ic_req_valid = 0; dc_req_valid = 0;
    burst(0, 5'd1, 128'h400);
  endtask

  task automatic test_hold;
    do_reset;
    ic_req_valid = 1; ic_req_addr = 28'h40; ic_req_tag = 5'd1; mem_req_ready = 0; #1;
    checks++; if (mem_req_addr !== 28'h40) begin errors++; $display("FAIL hold_sel got %0h exp 40", mem_req_addr); end
    tick;
    dc_req_valid = 1; dc_req_rw = 0; dc_req_addr = 28'h80; #1;
    checks++; if (mem_req_addr !== 28'h40) begin errors++; $display("FAIL hold_pinned got %0h exp 40", mem_req_addr); end
    mem_req_ready = 1; #1;
    checks++; if ({ic_req_ready, dc_req_ready} !== 2'b10) begin errors++; $display("FAIL hold_grant got %b exp 10", {ic_req_ready, dc_req_ready}); end
    tick;
    ic_req_valid = 0; dc_req_valid = 0;
    burst(0, 5'd1, 128'h500);
  endtask

  task automatic test_write;
    dc_req_valid = 1; dc_req_rw = 1; dc_req_addr = 28'h20; dc_req_tag = 5'd4;
    dc_req_data_valid = 1; dc_req_data_bits = 128'hDEADBEEF; dc_req_data_mask = 16'hFFFF;
    mem_req_ready = 0; mem_req_data_ready = 1; #1;
    checks++; if ({mem_req_valid, mem_req_rw, dc_req_ready, dc_req_data_ready, mem_req_data_valid} !== 5'b11000) begin errors++; $display("FAIL wr_early_data got %b exp 11000", {mem_req_valid, mem_req_rw, dc_req_ready, dc_req_data_ready, mem_req_data_valid}); end
    tick; #1;
    checks++; if ({dc_req_data_ready, mem_req_data_valid} !== 2'b00) begin errors++; $display("FAIL wr_data_blocked got %b exp 00", {dc_req_data_ready, mem_req_data_valid}); end
    mem_req_ready = 1; #1;
    checks++; if (dc_req_ready !== 1'b1) begin errors++; $display("FAIL wr_addr_ready got %b exp 1", dc_req_ready); end
    tick;
    dc_req_valid = 0; mem_req_data_ready = 0; #1;
    checks++; if ({mem_req_data_valid, dc_req_data_ready, mem_req_valid} !== 3'b100) begin errors++; $display("FAIL wr_data_state got %b exp 100", {mem_req_data_valid, dc_req_data_ready, mem_req_valid}); end
    checks++; if ({mem_req_data_bits, mem_req_data_mask} !== {128'hDEADBEEF, 16'hFFFF}) begin errors++; $display("FAIL wr_data_fields got %0h/%0h exp deadbeef/ffff", mem_req_data_bits, mem_req_data_mask); end
    tick;
    mem_req_data_ready = 1; #1;
    checks++; if (dc_req_data_ready !== 1'b1) begin errors++; $display("FAIL wr_data_ready got %b exp 1", dc_req_data_ready); end
    mem_word = mem_req_data_bits;
    tick;
    dc_req_data_valid = 0; mem_req_data_ready = 0;
    checks++; if (mem_word !== 128'hDEADBEEF) begin errors++; $display("FAIL wr_stored got %0h exp deadbeef", mem_word); end
    dc_req_valid = 1; dc_req_rw = 0; dc_req_addr = 28'h20; #1;
    checks++; if ({mem_req_addr, mem_req_rw, dc_req_ready} !== {28'h20, 2'b01}) begin errors++; $display("FAIL wr_readback_req got %0h/%b exp 20/01", mem_req_addr, {mem_req_rw, dc_req_ready}); end
    tick;
    dc_req_valid = 0;
    burst(1, 5'd4, mem_word);
  endtask

  task automatic test_spurious;
    mem_resp_valid = 1; mem_resp_data = 128'h55; #1;
    checks++; if ({ic_resp_valid, dc_resp_valid} !== 2'b00) begin errors++; $display("FAIL spur_drop got %b exp 00", {ic_resp_valid, dc_resp_valid}); end
    tick;
    mem_resp_valid = 0; ic_req_valid = 1; ic_req_addr = 28'h100; ic_req_tag = 5'd7; mem_req_ready = 1; #1;
    checks++; if ({mem_req_valid, ic_req_ready} !== 2'b11) begin errors++; $display("FAIL spur_still_idle got %b exp 11", {mem_req_valid, ic_req_ready}); end
    tick;
    ic_req_valid = 0;
    burst(0, 5'd7, 128'h600);
    ic_req_valid = 1; mem_req_ready = 0; #1;
    checks++; if (mem_req_valid !== 1'b1) begin errors++; $display("FAIL spur_burst_len got %b exp 1", mem_req_valid); end
    ic_req_valid = 0;
    tick;
  endtask

  task automatic test_reset_mid;
    ic_req_valid = 1; ic_req_addr = 28'h100; ic_req_tag = 5'd3; mem_req_ready = 1;
    tick;
    ic_req_valid = 0;
    for (int i = 0; i < 2; i++) begin
      mem_resp_valid = 1; mem_resp_data = 128'h700 + DW'(i); mem_resp_tag = 5'd3; #1;
      checks++; if (ic_resp_valid !== 1'b1) begin errors++; $display("FAIL rmid_beat %0d got %b exp 1", i, ic_resp_valid); end
      tick;
    end
    mem_resp_valid = 0; reset = 0;
    ic_req_valid = 1; dc_req_valid = 1; mem_req_data_ready = 1; dc_req_data_valid = 1; #1;
    checks++; if ({mem_req_valid, ic_req_ready, dc_req_ready, ic_resp_valid, dc_resp_valid, mem_req_data_valid, dc_req_data_ready} !== 7'b0) begin errors++; $display("FAIL rmid_outputs got %b exp 0", {mem_req_valid, ic_req_ready, dc_req_ready, ic_resp_valid, dc_resp_valid, mem_req_data_valid, dc_req_data_ready}); end
    tick;
    reset = 1; ic_req_valid = 0; dc_req_valid = 0; dc_req_data_valid = 0; mem_req_data_ready = 0;
    for (int i = 2; i < 4; i++) begin
      mem_resp_valid = 1; mem_resp_data = 128'h700 + DW'(i); #1;
      checks++; if ({ic_resp_valid, dc_resp_valid} !== 2'b00) begin errors++; $display("FAIL rmid_drop %0d got %b exp 00", i, {ic_resp_valid, dc_resp_valid}); end
      tick;
    end
    mem_resp_valid = 0;
    dc_req_valid = 1; dc_req_rw = 0; dc_req_addr = 28'h300; dc_req_tag = 5'd6; #1;
    checks++; if ({mem_req_addr, dc_req_ready} !== {28'h300, 1'b1}) begin errors++; $display("FAIL rmid_new_req got %0h/%b exp 300/1", mem_req_addr, dc_req_ready); end
    tick;
    dc_req_valid = 0;
    burst(1, 5'd6, 128'h800);
  endtask

  initial begin
    mem_word = '0;
    test_reset;
    test_ic_read;
    test_round_robin;
    test_hold;
    test_write;
    test_spurious;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
